// File: rtl/ring_arb_pkg.sv
// Shared types and default sizing for the ring round-robin arbiter.
package ring_arb_pkg;
  localparam int N_DEF        = 3;
  localparam int HOLD_MAX_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;
endpackage

// File: rtl/ring_ptr.sv
// One-hot ring priority pointer; rotates past the granted requester and
// snaps back to bit 0 whenever it is found corrupted.
module ring_ptr
  import ring_arb_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rotate,
  input  logic [N-1:0] gnt_oh,
  output logic [N-1:0] ptr,
  output logic         ptr_ok
);
  localparam logic [N-1:0] BIT0 = N'(1);

  logic [N-1:0] ptr_q, ptr_d;

  assign ptr_ok = (ptr_q != '0) && ((ptr_q & (ptr_q - BIT0)) == '0);
  assign ptr    = ptr_q;

  // Correction wins over rotation so a bad pointer never propagates.
  always_comb begin
    ptr_d = ptr_q;
    if (!ptr_ok)     ptr_d = BIT0;
    else if (rotate) ptr_d = {gnt_oh[N-2:0], gnt_oh[N-1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= BIT0;
    else      ptr_q <= ptr_d;
  end
endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot ring pointer, bounded hold time and
// a timeout pulse when a grant is forcibly released.
module ring_rr_arbiter
  import ring_arb_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] gnt,
  output logic         gnt_valid,
  output logic [N-1:0] ptr,
  output logic         timeout
);
  localparam int            CW   = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(HOLD_MAX);
  localparam logic [CW-1:0] CONE = CW'(1);

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d, pick, prio;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gv_q, to_q, to_d;
  logic          hold_req, at_max, rel, ptr_ok;
  int            base, idx;

  ring_ptr #(.N(N)) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .rotate (rel),
    .gnt_oh (gnt_q),
    .ptr    (ptr),
    .ptr_ok (ptr_ok)
  );

  // A corrupted pointer is read as bit 0 for this cycle's decision.
  assign prio = ptr_ok ? ptr : N'(1);

  always_comb begin
    pick = '0;
    base = 0;
    idx  = 0;
    for (int i = 0; i < N; i++)
      if (prio[i]) base = i;
    for (int k = 0; k < N; k++) begin
      idx = (base + k) % N;
      if (pick == '0 && req[idx]) pick[idx] = 1'b1;
    end
  end

  assign hold_req = |(req & gnt_q);
  assign at_max   = (cnt_q == CMAX);
  assign rel      = (state_q == GRANT) && (done || !hold_req || at_max);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      gv_q    <= 1'b0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gv_q    <= |gnt_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = GRANT;
      GRANT:   if (rel)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d = gnt_q;
    cnt_d = cnt_q;
    to_d  = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = pick;
        cnt_d = (|req) ? CONE : '0;
      end
      GRANT: begin
        if (rel) begin
          gnt_d = '0;
          cnt_d = '0;
          // Pulse only when the hold limit alone forced the release.
          to_d  = at_max && !done && hold_req;
        end else begin
          cnt_d = cnt_q + CONE;
        end
      end
      default: begin
        gnt_d = '0;
        cnt_d = '0;
      end
    endcase
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gv_q;
  assign timeout   = to_q;
endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Bench for ring_rr_arbiter (N=3, HOLD_MAX=4): directed scenarios plus a
// randomized run against a behavioural owner/pointer model.
module tb_ring_rr_arbiter;
  localparam int N = 3;
  localparam int HM = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] gnt, ptr;
  logic         gnt_valid, timeout;

  int checks = 0;
  int errors = 0;

  // model: owner index (-1 = none), priority index, grant cycle count
  int   m_own, m_ptr, m_cnt;
  logic m_to;

  ring_rr_arbiter #(.N(N), .HOLD_MAX(HM)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .ptr       (ptr),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_own = -1; m_ptr = 0; m_cnt = 0; m_to = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic d);
    int c;
    if (m_own < 0) begin
      m_to = 1'b0;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (m_own < 0 && r[c]) m_own = c;
      end
      if (m_own >= 0) m_cnt = 1;
    end else if (d || !r[m_own] || m_cnt == HM) begin
      m_to  = (m_cnt == HM) && !d && r[m_own];
      m_ptr = (m_own + 1) % N;
      m_own = -1;
      m_cnt = 0;
    end else begin
      m_cnt++;
      m_to = 1'b0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_step(req, done);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 3'b111; done = 1'b0;
    model_reset();
    repeat (3) cycle();
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b want 000", gnt); end
    checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_gv got %b want 0", gnt_valid); end
    checks++; if (ptr !== 3'b001) begin errors++; $display("FAIL reset_ptr got %b want 001", ptr); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_to got %b want 0", timeout); end
    req = 3'b000; rst = 1'b1;
    cycle();
    checks++; if (gnt !== 3'b000 || ptr !== 3'b001) begin errors++; $display("FAIL post_reset got gnt %b ptr %b want 000 001", gnt, ptr); end
  endtask

  task automatic test_rotation();
    logic [N-1:0] gseq [4];
    logic [N-1:0] pseq [4];
    gseq = '{3'b001, 3'b010, 3'b100, 3'b001};
    pseq = '{3'b010, 3'b100, 3'b001, 3'b010};
    req = 3'b111; done = 1'b0;
    for (int g = 0; g < 4; g++) begin
      cycle();
      checks++; if (gnt !== gseq[g] || gnt_valid !== 1'b1) begin errors++; $display("FAIL rot_c1[%0d] got %b/%b want %b/1", g, gnt, gnt_valid, gseq[g]); end
      cycle();
      checks++; if (gnt !== gseq[g]) begin errors++; $display("FAIL rot_c2[%0d] got %b want %b", g, gnt, gseq[g]); end
      done = 1'b1;
      cycle();
      done = 1'b0;
      checks++; if (gnt !== 3'b000 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL rot_idle[%0d] got gnt %b gv %b to %b want 000 0 0", g, gnt, gnt_valid, timeout); end
      checks++; if (ptr !== pseq[g]) begin errors++; $display("FAIL rot_ptr[%0d] got %b want %b", g, ptr, pseq[g]); end
    end
  endtask

  task automatic test_ptr_skip();
    req = 3'b101;
    cycle();
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL skip_gnt got %b want 100", gnt); end
    done = 1'b1;
    cycle();
    done = 1'b0; req = 3'b000;
    checks++; if (gnt !== 3'b000 || ptr !== 3'b001) begin errors++; $display("FAIL skip_rel got gnt %b ptr %b want 000 001", gnt, ptr); end
  endtask

  task automatic test_timeout();
    req = 3'b001; done = 1'b0;
    for (int i = 1; i <= HM; i++) begin
      cycle();
      checks++; if (gnt !== 3'b001 || timeout !== 1'b0) begin errors++; $display("FAIL to_hold[%0d] got gnt %b to %b want 001 0", i, gnt, timeout); end
    end
    cycle();
    checks++; if (gnt !== 3'b000 || timeout !== 1'b1) begin errors++; $display("FAIL to_pulse got gnt %b to %b want 000 1", gnt, timeout); end
    cycle();
    checks++; if (gnt !== 3'b001 || timeout !== 1'b0 || ptr !== 3'b010) begin errors++; $display("FAIL to_regrant got gnt %b to %b ptr %b want 001 0 010", gnt, timeout, ptr); end
    req = 3'b000;
    cycle();
    checks++; if (gnt !== 3'b000 || timeout !== 1'b0) begin errors++; $display("FAIL to_drop got gnt %b to %b want 000 0", gnt, timeout); end
  endtask

  task automatic test_done_at_max();
    req = 3'b001; done = 1'b0;
    for (int i = 1; i <= HM; i++) begin
      cycle();
      checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL dmax_hold[%0d] got %b want 001", i, gnt); end
    end
    done = 1'b1;
    cycle();
    done = 1'b0; req = 3'b000;
    checks++; if (gnt !== 3'b000 || timeout !== 1'b0) begin errors++; $display("FAIL dmax_rel got gnt %b to %b want 000 0", gnt, timeout); end
    cycle();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL dmax_after got to %b want 0", timeout); end
  endtask

  task automatic test_reset_mid();
    req = 3'b010;
    cycle();
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL mid_pre got %b want 010", gnt); end
    #2 rst = 1'b0;
    #1;
    checks++; if (gnt !== 3'b000 || gnt_valid !== 1'b0 || ptr !== 3'b001) begin errors++; $display("FAIL mid_reset got gnt %b gv %b ptr %b want 000 0 001", gnt, gnt_valid, ptr); end
    model_reset();
    req = 3'b000;
    #1 rst = 1'b1;
    cycle();
  endtask

  task automatic test_ptr_force();
    req = 3'b110;
    force dut.u_ptr.ptr_q = 3'b011;
    #1;
    checks++; if (ptr !== 3'b011) begin errors++; $display("FAIL force_a got ptr %b want 011", ptr); end
    release dut.u_ptr.ptr_q;
    m_ptr = 0;
    cycle();
    checks++; if (ptr !== 3'b001 || gnt !== 3'b010) begin errors++; $display("FAIL force_a_fix got ptr %b gnt %b want 001 010", ptr, gnt); end
    done = 1'b1;
    cycle();
    done = 1'b0; req = 3'b000;
    checks++; if (ptr !== 3'b100) begin errors++; $display("FAIL force_a_rot got ptr %b want 100", ptr); end
    req = 3'b111;
    force dut.u_ptr.ptr_q = 3'b000;
    #1;
    release dut.u_ptr.ptr_q;
    m_ptr = 0;
    cycle();
    checks++; if (ptr !== 3'b001 || gnt !== 3'b001) begin errors++; $display("FAIL force_b_fix got ptr %b gnt %b want 001 001", ptr, gnt); end
    req = 3'b000; done = 1'b1;
    cycle();
    done = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    logic [N-1:0] eg;
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 7));
      done = ($urandom_range(0, 6) == 0);
      cycle();
      eg = oh(m_own);
      checks++; if (gnt !== eg || gnt_valid !== (|eg)) begin errors++; $display("FAIL rnd_gnt t=%0d got %b/%b want %b/%b", t, gnt, gnt_valid, eg, |eg); end
      checks++; if (ptr !== oh(m_ptr)) begin errors++; $display("FAIL rnd_ptr t=%0d got %b want %b", t, ptr, oh(m_ptr)); end
      checks++; if (timeout !== m_to) begin errors++; $display("FAIL rnd_to t=%0d got %b want %b", t, timeout, m_to); end
    end
    req = '0; done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_ptr_skip();
    test_timeout();
    test_done_at_max();
    test_reset_mid();
    test_ptr_force();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
